// File: rtl/mem_access_pkg.sv
// Shared definitions for the data-memory access unit: funct3 codes,
// FSM state encodings and the access-size decode.
package mem_access_pkg;

   // RISC-V load/store funct3 encodings (stores use the first four)
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_D  = 3'b011;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [2:0] F3_WU = 3'b110;

   // FSM state encodings
   typedef logic [2:0] state_t;
   localparam state_t ST_IDLE   = 3'd0;
   localparam state_t ST_LOAD   = 3'd1;
   localparam state_t ST_RMW_RD = 3'd2;
   localparam state_t ST_WRITE  = 3'd3;
   localparam state_t ST_RESP   = 3'd4;

   // Access size in bytes; the low two funct3 bits encode log2(size)
   function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
      case (funct3[1:0])
         2'b00:   size_bytes = 4'd1;
         2'b01:   size_bytes = 4'd2;
         2'b10:   size_bytes = 4'd4;
         default: size_bytes = 4'd8;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Combinational byte-lane steering between a memory doubleword and
// sub-doubleword load/store data (little-endian lanes).
import mem_access_pkg::*;

module mem_access_unit_lane_align (
   input  logic [63:0] dword,
   input  logic [63:0] wdata,
   input  logic [2:0]  offset,
   input  logic [2:0]  funct3,
   output logic [63:0] load_data,
   output logic [63:0] store_data
);

   // Pull the addressed lane down to bit 0 and sign/zero extend it
   function automatic logic [63:0] load_extract(input logic [63:0] dw,
                                                input logic [2:0]  off,
                                                input logic [2:0]  f3);
      logic [63:0] s;
      s = dw >> {off, 3'b000};
      case (f3)
         F3_B:    load_extract = {{56{s[7]}}, s[7:0]};
         F3_H:    load_extract = {{48{s[15]}}, s[15:0]};
         F3_W:    load_extract = {{32{s[31]}}, s[31:0]};
         F3_D:    load_extract = s;
         F3_BU:   load_extract = {56'd0, s[7:0]};
         F3_HU:   load_extract = {48'd0, s[15:0]};
         F3_WU:   load_extract = {32'd0, s[31:0]};
         default: load_extract = 64'd0;
      endcase
   endfunction

   // Replace the addressed lane of the old doubleword with the low store bytes
   function automatic logic [63:0] store_merge(input logic [63:0] dw,
                                               input logic [63:0] wd,
                                               input logic [2:0]  off,
                                               input logic [2:0]  f3);
      logic [63:0] base_mask;
      logic [63:0] lane_mask;
      case (f3[1:0])
         2'b00:   base_mask = 64'h0000_0000_0000_00FF;
         2'b01:   base_mask = 64'h0000_0000_0000_FFFF;
         2'b10:   base_mask = 64'h0000_0000_FFFF_FFFF;
         default: base_mask = 64'hFFFF_FFFF_FFFF_FFFF;
      endcase
      lane_mask   = base_mask << {off, 3'b000};
      store_merge = (dw & ~lane_mask) | ((wd << {off, 3'b000}) & lane_mask);
   endfunction

   // Both paths are evaluated continuously; the FSM picks which one to latch
   always_comb begin
      load_data  = load_extract(dword, offset, funct3);
      store_data = store_merge(dword, wdata, offset, funct3);
   end

endmodule

// File: rtl/mem_access_unit.sv
// Initiator side of the data-memory interface: turns byte/half/word/double
// loads and stores into doubleword-aligned memory transactions, using a
// read-modify-write for narrow stores and faulting bad requests up front.
import mem_access_pkg::*;

module mem_access_unit #(
   parameter int MEM_ADDR_BITS = 13
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [2:0]  req_funct3,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   output logic        resp_valid,
   output logic [63:0] resp_rdata,
   output logic        resp_fault,
   output logic        mem_read,
   output logic        mem_write,
   output logic [63:0] mem_address,
   output logic [63:0] mem_write_data,
   input  logic [63:0] mem_read_data
);

   state_t      state_q, state_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [2:0]  offset_q, offset_d;
   logic [63:0] wdata_q, wdata_d;
   logic [63:0] resp_rdata_q, resp_rdata_d;
   logic        resp_fault_q, resp_fault_d;
   logic [63:0] mem_address_q, mem_address_d;
   logic [63:0] mem_write_data_q, mem_write_data_d;

   logic [3:0]  req_size;
   logic [3:0]  req_size_m1;
   logic        req_misaligned;
   logic        req_out_of_range;
   logic        req_illegal;
   logic        req_fault;
   logic [63:0] load_data;
   logic [63:0] store_data;

   mem_access_unit_lane_align u_lane_align (
      .dword      (mem_read_data),
      .wdata      (wdata_q),
      .offset     (offset_q),
      .funct3     (funct3_q),
      .load_data  (load_data),
      .store_data (store_data)
   );

   // Classify the incoming request so faults never touch memory
   always_comb begin
      req_size         = size_bytes(req_funct3);
      req_size_m1      = req_size - 4'd1;
      req_misaligned   = (req_addr[2:0] & req_size_m1[2:0]) != 3'b000;
      req_out_of_range = (req_addr >> MEM_ADDR_BITS) != 64'd0;
      req_illegal      = req_write ? req_funct3[2] : (req_funct3 == 3'b111);
      req_fault        = req_illegal || req_misaligned || req_out_of_range;
   end

   // Next-state and datapath register updates for the access FSM
   always_comb begin
      state_d          = state_q;
      funct3_d         = funct3_q;
      offset_d         = offset_q;
      wdata_d          = wdata_q;
      resp_rdata_d     = resp_rdata_q;
      resp_fault_d     = resp_fault_q;
      mem_address_d    = mem_address_q;
      mem_write_data_d = mem_write_data_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               funct3_d = req_funct3;
               offset_d = req_addr[2:0];
               wdata_d  = req_wdata;
               if (req_fault) begin
                  resp_fault_d = 1'b1;
                  resp_rdata_d = 64'd0;
                  state_d      = ST_RESP;
               end else begin
                  mem_address_d = {req_addr[63:3], 3'b000};
                  if (!req_write) begin
                     state_d = ST_LOAD;
                  end else if (req_funct3 == F3_D) begin
                     mem_write_data_d = req_wdata;
                     state_d          = ST_WRITE;
                  end else begin
                     state_d = ST_RMW_RD;
                  end
               end
            end
         end
         ST_LOAD: begin
            resp_rdata_d = load_data;
            resp_fault_d = 1'b0;
            state_d      = ST_RESP;
         end
         ST_RMW_RD: begin
            mem_write_data_d = store_data;
            state_d          = ST_WRITE;
         end
         ST_WRITE: begin
            resp_rdata_d = 64'd0;
            resp_fault_d = 1'b0;
            state_d      = ST_RESP;
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q          <= ST_IDLE;
         funct3_q         <= 3'd0;
         offset_q         <= 3'd0;
         wdata_q          <= 64'd0;
         resp_rdata_q     <= 64'd0;
         resp_fault_q     <= 1'b0;
         mem_address_q    <= 64'd0;
         mem_write_data_q <= 64'd0;
      end else begin
         state_q          <= state_d;
         funct3_q         <= funct3_d;
         offset_q         <= offset_d;
         wdata_q          <= wdata_d;
         resp_rdata_q     <= resp_rdata_d;
         resp_fault_q     <= resp_fault_d;
         mem_address_q    <= mem_address_d;
         mem_write_data_q <= mem_write_data_d;
      end
   end

   // Moore decode of strobes plus registered data outputs
   always_comb begin
      req_ready      = (state_q == ST_IDLE);
      mem_read       = (state_q == ST_LOAD) || (state_q == ST_RMW_RD);
      mem_write      = (state_q == ST_WRITE);
      resp_valid     = (state_q == ST_RESP);
      resp_rdata     = resp_rdata_q;
      resp_fault     = resp_fault_q;
      mem_address    = mem_address_q;
      mem_write_data = mem_write_data_q;
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a small
// doubleword memory model (combinational read, posedge write).
module tb_mem_access_unit;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [2:0]  req_funct3;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic        resp_valid;
   logic [63:0] resp_rdata;
   logic        resp_fault;
   logic        mem_read;
   logic        mem_write;
   logic [63:0] mem_address;
   logic [63:0] mem_write_data;
   logic [63:0] mem_read_data;

   logic [63:0] mem [0:1023];
   logic        do_init;

   int          checks_cnt;
   int          errors_cnt;
   int          rd_total;
   int          wr_total;
   int          resp_total;
   logic [63:0] rd_addr_seen;
   logic [63:0] wr_addr_seen;
   logic [63:0] wr_data_seen;

   int          lat_obs;
   int          rd_delta;
   int          wr_delta;
   logic [63:0] rdata_obs;
   logic        fault_obs;

   mem_access_unit #(.MEM_ADDR_BITS(13)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_write      (req_write),
      .req_funct3     (req_funct3),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .resp_valid     (resp_valid),
      .resp_rdata     (resp_rdata),
      .resp_fault     (resp_fault),
      .mem_read       (mem_read),
      .mem_write      (mem_write),
      .mem_address    (mem_address),
      .mem_write_data (mem_write_data),
      .mem_read_data  (mem_read_data)
   );

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: combinational read, synchronous write, preload on init
   assign mem_read_data = mem[mem_address[12:3]];
   always @(posedge clk) begin
      if (do_init) begin
         for (int i = 0; i < 1024; i++) mem[i] <= 64'd0;
         mem[0]    <= 64'd11;
         mem[1]    <= 64'd20;
         mem[2]    <= 64'd30;
         mem[1023] <= 64'h8000_0000_0000_0001;
      end else if (mem_write) begin
         mem[mem_address[12:3]] <= mem_write_data;
      end
   end

   // Strobe monitor: cumulative counts of memory and response activity
   initial begin
      rd_total = 0;
      wr_total = 0;
      resp_total = 0;
      rd_addr_seen = 64'd0;
      wr_addr_seen = 64'd0;
      wr_data_seen = 64'd0;
   end
   always @(posedge clk) begin
      if (mem_read) begin
         rd_total = rd_total + 1;
         rd_addr_seen = mem_address;
      end
      if (mem_write) begin
         wr_total = wr_total + 1;
         wr_addr_seen = mem_address;
         wr_data_seen = mem_write_data;
      end
      if (resp_valid) resp_total = resp_total + 1;
   end

   // Single comparison point for every check in the bench
   task automatic checkOutput(input string tag, input logic [63:0] actual,
                              input logic [63:0] expected);
      checks_cnt++;
      if (actual !== expected) begin
         errors_cnt++;
         $display("[TB] FAIL %s: got 0x%016h expected 0x%016h", tag, actual, expected);
      end
   endtask

   // Wait for IDLE, issue one request and measure latency and strobes
   task automatic applyStimulus(input logic wr, input logic [2:0] f3,
                                input logic [63:0] addr, input logic [63:0] wd);
      int rd0;
      int wr0;
      int waited;
      waited = 0;
      @(negedge clk);
      while (!req_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (!req_ready) checkOutput("ready_wait", {63'd0, req_ready}, 64'd1);
      rd0 = rd_total;
      wr0 = wr_total;
      req_valid  = 1'b1;
      req_write  = wr;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wd;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      lat_obs = 0;
      while (lat_obs < 8) begin
         if (lat_obs > 0) begin
            @(posedge clk);
            #1;
         end
         lat_obs++;
         if (resp_valid) break;
         if (lat_obs == 1) begin
            @(posedge clk);
            #1;
            lat_obs++;
            if (resp_valid) begin
               lat_obs = 2;
               break;
            end
            lat_obs = 2;
         end
      end
      if (!resp_valid) lat_obs = 99;
      rdata_obs = resp_rdata;
      fault_obs = resp_fault;
      rd_delta  = rd_total - rd0;
      wr_delta  = wr_total - wr0;
   endtask

   initial begin
      checks_cnt = 0;
      errors_cnt = 0;
      req_valid  = 1'b0;
      req_write  = 1'b0;
      req_funct3 = 3'd0;
      req_addr   = 64'd0;
      req_wdata  = 64'd0;
      do_init    = 1'b1;
      rst_n      = 1'b0;
      #1;
      checkOutput("rst_req_ready", {63'd0, req_ready}, 64'd1);
      checkOutput("rst_mem_read", {63'd0, mem_read}, 64'd0);
      checkOutput("rst_mem_write", {63'd0, mem_write}, 64'd0);
      checkOutput("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
      checkOutput("rst_resp_fault", {63'd0, resp_fault}, 64'd0);
      checkOutput("rst_resp_rdata", resp_rdata, 64'd0);
      checkOutput("rst_mem_address", mem_address, 64'd0);
      checkOutput("rst_mem_wdata", mem_write_data, 64'd0);
      @(posedge clk);
      @(negedge clk);
      do_init = 1'b0;
      rst_n   = 1'b1;

      $display("[TB] test 1: LD 0x8");
      applyStimulus(1'b0, 3'b011, 64'h8, 64'd0);
      checkOutput("ld8_latency", 64'(lat_obs), 64'd2);
      checkOutput("ld8_rdata", rdata_obs, 64'd20);
      checkOutput("ld8_fault", {63'd0, fault_obs}, 64'd0);
      checkOutput("ld8_rd_cycles", 64'(rd_delta), 64'd1);
      checkOutput("ld8_wr_cycles", 64'(wr_delta), 64'd0);
      checkOutput("ld8_rd_addr", rd_addr_seen, 64'h8);
      @(posedge clk);
      #1;
      checkOutput("ld8_pulse_low", {63'd0, resp_valid}, 64'd0);

      $display("[TB] test 2: SB 0xFF at 0x11");
      applyStimulus(1'b1, 3'b000, 64'h11, 64'h0000_0000_0000_00FF);
      checkOutput("sb_latency", 64'(lat_obs), 64'd3);
      checkOutput("sb_rd_cycles", 64'(rd_delta), 64'd1);
      checkOutput("sb_wr_cycles", 64'(wr_delta), 64'd1);
      checkOutput("sb_wr_data", wr_data_seen, 64'h0000_0000_0000_FF1E);
      checkOutput("sb_wr_addr", wr_addr_seen, 64'h10);
      checkOutput("sb_rdata", rdata_obs, 64'd0);
      applyStimulus(1'b0, 3'b000, 64'h11, 64'd0);
      checkOutput("lb11_rdata", rdata_obs, 64'hFFFF_FFFF_FFFF_FFFF);
      applyStimulus(1'b0, 3'b100, 64'h11, 64'd0);
      checkOutput("lbu11_rdata", rdata_obs, 64'h0000_0000_0000_00FF);
      applyStimulus(1'b0, 3'b011, 64'h10, 64'd0);
      checkOutput("ld10_rdata", rdata_obs, 64'h0000_0000_0000_FF1E);

      $display("[TB] test 3: SD then word/half loads");
      applyStimulus(1'b1, 3'b011, 64'h8, 64'hDEAD_BEEF_CAFE_F00D);
      checkOutput("sd_latency", 64'(lat_obs), 64'd2);
      checkOutput("sd_rd_cycles", 64'(rd_delta), 64'd0);
      checkOutput("sd_wr_data", wr_data_seen, 64'hDEAD_BEEF_CAFE_F00D);
      applyStimulus(1'b0, 3'b010, 64'hC, 64'd0);
      checkOutput("lwc_rdata", rdata_obs, 64'hFFFF_FFFF_DEAD_BEEF);
      applyStimulus(1'b0, 3'b110, 64'hC, 64'd0);
      checkOutput("lwuc_rdata", rdata_obs, 64'h0000_0000_DEAD_BEEF);
      applyStimulus(1'b0, 3'b001, 64'h8, 64'd0);
      checkOutput("lh8_rdata", rdata_obs, 64'hFFFF_FFFF_FFFF_F00D);

      $display("[TB] test 4: misaligned LH");
      applyStimulus(1'b0, 3'b001, 64'h3, 64'd0);
      checkOutput("lh3_latency", 64'(lat_obs), 64'd1);
      checkOutput("lh3_fault", {63'd0, fault_obs}, 64'd1);
      checkOutput("lh3_rdata", rdata_obs, 64'd0);
      checkOutput("lh3_rd_cycles", 64'(rd_delta), 64'd0);
      checkOutput("lh3_wr_cycles", 64'(wr_delta), 64'd0);
      @(posedge clk);
      #1;
      checkOutput("fault_hold", {63'd0, resp_fault}, 64'd1);

      $display("[TB] test 5: out-of-range and illegal store");
      applyStimulus(1'b0, 3'b011, 64'h2000, 64'd0);
      checkOutput("ld2000_fault", {63'd0, fault_obs}, 64'd1);
      checkOutput("ld2000_strobes", 64'(rd_delta + wr_delta), 64'd0);
      applyStimulus(1'b1, 3'b100, 64'h0, 64'h55);
      checkOutput("st100_fault", {63'd0, fault_obs}, 64'd1);
      checkOutput("st100_strobes", 64'(rd_delta + wr_delta), 64'd0);
      checkOutput("mem0_kept", mem[0], 64'd11);
      applyStimulus(1'b0, 3'b011, 64'h1FF8, 64'd0);
      checkOutput("ld_top_fault", {63'd0, fault_obs}, 64'd0);
      checkOutput("ld_top_rdata", rdata_obs, 64'h8000_0000_0000_0001);
      applyStimulus(1'b0, 3'b000, 64'h1FFF, 64'd0);
      checkOutput("lb_top_rdata", rdata_obs, 64'hFFFF_FFFF_FFFF_FF80);
      applyStimulus(1'b1, 3'b001, 64'h5, 64'h1234);
      checkOutput("sh5_fault", {63'd0, fault_obs}, 64'd1);

      $display("[TB] test 6: reset during RMW read");
      begin
         int wr0;
         int resp0;
         @(negedge clk);
         while (!req_ready) @(negedge clk);
         wr0   = wr_total;
         resp0 = resp_total;
         req_valid  = 1'b1;
         req_write  = 1'b1;
         req_funct3 = 3'b010;
         req_addr   = 64'h0;
         req_wdata  = 64'h1234_5678;
         @(posedge clk);
         #1;
         req_valid = 1'b0;
         checkOutput("rmw_mem_read", {63'd0, mem_read}, 64'd1);
         rst_n = 1'b0;
         #1;
         checkOutput("abort_mem_read", {63'd0, mem_read}, 64'd0);
         checkOutput("abort_mem_write", {63'd0, mem_write}, 64'd0);
         checkOutput("abort_mem_address", mem_address, 64'd0);
         checkOutput("abort_mem_wdata", mem_write_data, 64'd0);
         checkOutput("abort_resp_rdata", resp_rdata, 64'd0);
         checkOutput("abort_resp_fault", {63'd0, resp_fault}, 64'd0);
         checkOutput("abort_resp_valid", {63'd0, resp_valid}, 64'd0);
         @(negedge clk);
         @(negedge clk);
         rst_n = 1'b1;
         @(negedge clk);
         checkOutput("abort_req_ready", {63'd0, req_ready}, 64'd1);
         repeat (3) @(negedge clk);
         checkOutput("abort_no_write", 64'(wr_total - wr0), 64'd0);
         checkOutput("abort_no_resp", 64'(resp_total - resp0), 64'd0);
         checkOutput("abort_mem0", mem[0], 64'd11);
      end

      $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
      $finish;
   end

   // Global watchdog so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Initiator side of the data-memory interface. It accepts load/store requests from the pipeline MEM stage and drives the memory's mem_read, mem_write, address and write_data strobes. The memory is doubleword-organised, with a combinational read and a synchronous write, so this block converts RISC-V byte, half and word accesses into 8-byte-aligned transactions. Sub-doubleword stores use a two-cycle read-modify-write; loads are lane-extracted and sign- or zero-extended. Misaligned and out-of-range requests are flagged and never reach memory.

Parameters:
MEM_ADDR_BITS, 13, number of byte-address bits covered by memory (1024 x 8 bytes); any request address with a set bit at or above this position faults.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  unit can accept a request (high only in IDLE)
req_write  input  1  1 = store, 0 = load
req_funct3  input  3  RISC-V funct3 (LB/LH/LW/LD/LBU/LHU/LWU; SB/SH/SW/SD)
req_addr  input  64  byte address
req_wdata  input  64  store data; the low bytes are used for sub-doubleword stores
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  64  extended load data; 0 for stores and faults
resp_fault  output  1  valid with resp_valid: misaligned, out-of-range or illegal funct3
mem_read  output  1  memory read strobe
mem_write  output  1  memory write strobe, sampled by memory at posedge
mem_address  output  64  doubleword-aligned address, bits [2:0] always 0
mem_write_data  output  64  write data
mem_read_data  input  64  combinational read data from memory

Behaviour:
- States:
  - IDLE: req_ready=1.
  - LOAD: mem_read=1.
  - RMW_RD: mem_read=1.
  - WRITE: mem_write=1.
  - RESP: resp_valid=1.
- mem_read, mem_write, req_ready and resp_valid are decoded from state only (Moore). mem_address and mem_write_data come from registers.
- Reset (async, rst_n=0): state to IDLE; mem_read=0, mem_write=0, resp_valid=0, resp_fault=0, resp_rdata=0, mem_address=0, mem_write_data=0; req_ready=1 once in IDLE.
- Accept: at a posedge with state IDLE and req_valid=1, latch write, funct3, addr, wdata.
- Fault at accept (checked first):
  - Misaligned: H with addr[0]!=0; W with addr[1:0]!=0; D with addr[2:0]!=0.
  - Out of range: addr[63:MEM_ADDR_BITS]!=0.
  - Illegal funct3: funct3=111 for a load; funct3 >= 100 for a store.
  - Action: go to RESP with resp_fault=1 and resp_rdata=0. No memory strobe.
- Transitions:
  - IDLE: load -> LOAD; SD -> WRITE with mem_write_data=wdata; SB/SH/SW -> RMW_RD.
  - LOAD: at posedge, resp_rdata is set from mem_read_data (byte offset off=addr[2:0], lane bits [8*off +: size]), sign-extended for LB/LH/LW and zero-extended for LBU/LHU/LWU/LD. Then -> RESP.
  - RMW_RD: at posedge, mem_write_data is set to mem_read_data with the addressed lane replaced by the low bytes of wdata. Then -> WRITE.
  - WRITE: -> RESP; resp_rdata=0.
  - RESP: -> IDLE. No new request is accepted in RESP.
- Latency from accept edge to resp_valid high:
  - fault: 1 cycle
  - load: 2 cycles
  - SD: 2 cycles
  - SB/SH/SW: 3 cycles
- Throughput: one request per (latency+1) cycles.
- mem_address = {addr[63:3], 3'b000} throughout LOAD, RMW_RD and WRITE.
- Byte lanes are little-endian.
- resp_rdata and resp_fault hold their value until the next RESP.
- Reset mid-operation: any in-flight store is abandoned. A reset in RMW_RD means mem_write is never asserted and memory is unchanged. No resp_valid is produced for the aborted request.
- req_valid may drop without being accepted; the unit samples it only in IDLE.

Decomposition:
- Shared package mem_access_pkg:
  - funct3 localparams (F3_B=000, F3_H=001, F3_W=010, F3_D=011, F3_BU=100, F3_HU=101, F3_WU=110);
  - state enum;
  - size-decode function.
- Sub-module lane_align (combinational), with two functions:
  - load extract plus sign/zero extend (inputs: dword, offset, funct3);
  - store merge (inputs: dword, wdata, offset, funct3).
- The FSM and registers live in mem_access_unit.

Test Plan (memory preloaded with mem[0]=11, mem[1]=20, mem[2]=30):
1. LD addr 0x8 -> mem_read high exactly 1 cycle with mem_address=0x8; resp_valid 2 cycles after accept; resp_rdata=20, resp_fault=0.
2. SB wdata 0xFF, addr 0x11 -> mem_read for 1 cycle, then mem_write for 1 cycle with data 0x000000000000FF1E. Then LB 0x11 -> 0xFFFFFFFFFFFFFFFF; LBU 0x11 -> 0x00000000000000FF; LD 0x10 -> 0xFF1E.
3. SD 0xDEADBEEFCAFEF00D, addr 0x8 (response 2 cycles after accept) -> LW 0xC gives 0xFFFFFFFFDEADBEEF; LWU 0xC gives 0x00000000DEADBEEF; LH 0x8 gives 0xFFFFFFFFFFFFF00D.
4. LH addr 0x3 -> resp_valid 1 cycle after accept with resp_fault=1 and resp_rdata=0; mem_read and mem_write never asserted.
5. LD addr 0x2000, and store funct3=100 at addr 0x0 -> resp_fault=1 for each; no memory strobes; mem[0] still 11.
6. SW 0x12345678 at addr 0x0; pull rst_n low during RMW_RD -> mem_write never asserted; mem[0]=11; all outputs at reset values; req_ready=1 after release.
